// File: rtl/vector_pkg.sv
// Shared vector register-file constants and the gather sequencer state type.
package vector_pkg;

  localparam int VECTOR_REG_DEPTH = 32;
  localparam int VECTOR_REG_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } map_sched_state_e;

endpackage

// File: rtl/vector_map_grant.sv
// Conflict-free lane selection: for every distinct pending address, grant only
// the lowest-indexed lane that names it.
module vector_map_grant #(
  parameter int MAP_PORT = 8,
  parameter int ADDR_W   = 5
) (
  input  logic [MAP_PORT-1:0]        pending,
  input  logic [MAP_PORT*ADDR_W-1:0] addr,
  output logic [MAP_PORT-1:0]        grant
);

  always_comb begin
    // NOTE: default every bit first so no path leaves grant unassigned (no latch).
    grant = '0;
    for (int i = 0; i < MAP_PORT; i++) begin
      grant[i] = pending[i];
      for (int k = 0; k < i; k++) begin
        if (pending[k] && (addr[k*ADDR_W +: ADDR_W] == addr[i*ADDR_W +: ADDR_W]))
          grant[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/vector_map_sched.sv
// Gather sequencer: splits a lane-masked request into conflict-free mapper
// passes, collects per-lane data, and returns the whole vector.
module vector_map_sched
  import vector_pkg::*;
#(
  parameter int MAP_PORT = 8,
  parameter int ADDR_W   = $clog2(VECTOR_REG_DEPTH),
  parameter int DATA_W   = VECTOR_REG_WIDTH,
  localparam int PASS_W  = $clog2(MAP_PORT) + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_vld,
  output logic                        req_rdy,
  input  logic [MAP_PORT-1:0]         req_mask,
  input  logic [MAP_PORT*ADDR_W-1:0]  req_addr,
  output logic [MAP_PORT-1:0]         map_vld,
  output logic [MAP_PORT*ADDR_W-1:0]  map_addr,
  input  logic [MAP_PORT*DATA_W-1:0]  map_data,
  output logic                        rsp_vld,
  input  logic                        rsp_rdy,
  output logic [MAP_PORT*DATA_W-1:0]  rsp_data,
  output logic [PASS_W-1:0]           rsp_passes
);

  map_sched_state_e            state;
  logic [MAP_PORT-1:0]         pending;
  logic [MAP_PORT-1:0]         grant;
  logic [MAP_PORT-1:0]         remain;
  logic [MAP_PORT*ADDR_W-1:0]  addr_q;
  logic [MAP_PORT*DATA_W-1:0]  buf_q;
  logic [PASS_W-1:0]           passes_q;

  vector_map_grant #(
    .MAP_PORT (MAP_PORT),
    .ADDR_W   (ADDR_W)
  ) u_grant (
    .pending (pending),
    .addr    (addr_q),
    .grant   (grant)
  );

  assign remain     = pending & ~grant;
  assign req_rdy    = (state == IDLE);
  assign rsp_vld    = (state == DONE);
  assign map_vld    = (state == ISSUE) ? grant : '0;
  assign map_addr   = addr_q;
  assign rsp_data   = buf_q;
  assign rsp_passes = passes_q;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= '0;
      addr_q   <= '0;
      // NOTE: the result buffer is reset because rsp_data must read 0 after reset.
      buf_q    <= '0;
      passes_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_vld) begin
            addr_q   <= req_addr;
            pending  <= req_mask;
            buf_q    <= '0;
            passes_q <= '0;
            state    <= (req_mask != '0) ? ISSUE : DONE;
          end
        end
        ISSUE: begin
          for (int i = 0; i < MAP_PORT; i++) begin
            if (grant[i])
              buf_q[i*DATA_W +: DATA_W] <= map_data[i*DATA_W +: DATA_W];
          end
          pending  <= remain;
          passes_q <= passes_q + 1'b1;
          if (remain == '0)
            state <= DONE;
        end
        DONE: begin
          if (rsp_rdy)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_map_sched.sv
// Directed bench for vector_map_sched with a behavioural register-file mapper
// and a scoreboard of expected responses.
module tb_vector_map_sched;

  localparam int MAP_PORT = 8;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 16;
  localparam int PASS_W   = 4;

  logic                        clk;
  logic                        reset;
  logic                        req_vld;
  logic                        req_rdy;
  logic [MAP_PORT-1:0]         req_mask;
  logic [MAP_PORT*ADDR_W-1:0]  req_addr;
  logic [MAP_PORT-1:0]         map_vld;
  logic [MAP_PORT*ADDR_W-1:0]  map_addr;
  logic [MAP_PORT*DATA_W-1:0]  map_data;
  logic                        rsp_vld;
  logic                        rsp_rdy;
  logic [MAP_PORT*DATA_W-1:0]  rsp_data;
  logic [PASS_W-1:0]           rsp_passes;

  typedef struct {
    logic [MAP_PORT*DATA_W-1:0] data;
    logic [PASS_W-1:0]          passes;
  } exp_t;

  exp_t               exp_q[$];
  logic [MAP_PORT-1:0] grant_q[$];
  int                 checks = 0;
  int                 errors = 0;

  vector_map_sched #(
    .MAP_PORT (MAP_PORT),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_mask   (req_mask),
    .req_addr   (req_addr),
    .map_vld    (map_vld),
    .map_addr   (map_addr),
    .map_data   (map_data),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_data   (rsp_data),
    .rsp_passes (rsp_passes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file holds 0x100+addr; lanes not granted return junk so a stray
  // capture shows up in the result.
  always_comb begin
    map_data = '0;
    for (int i = 0; i < MAP_PORT; i++)
      map_data[i*DATA_W +: DATA_W] = map_vld[i] ? (16'h0100 + 16'(map_addr[i*ADDR_W +: ADDR_W]))
                                                : 16'hDEAD;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_rdy"},    req_rdy,    1'b1);
    check({tag, "_rsp_vld"},    rsp_vld,    1'b0);
    check({tag, "_map_vld"},    map_vld,    '0);
    check({tag, "_map_addr"},   map_addr,   '0);
    check({tag, "_rsp_data"},   rsp_data,   '0);
    check({tag, "_rsp_passes"}, rsp_passes, '0);
  endtask

  // hold < 0: rsp_rdy already high when rsp_vld rises; hold >= 0: cycles of back-pressure.
  task automatic run_req(input logic [MAP_PORT-1:0] mask, input logic [MAP_PORT*ADDR_W-1:0] addr,
                         input int hold, input bit chk_grant, input bit pulse_req);
    exp_t e;
    exp_t got;
    int   cyc;
    int   mult;
    logic [MAP_PORT-1:0] g;
    e.data = '0;
    e.passes = '0;
    for (int i = 0; i < MAP_PORT; i++) begin
      if (mask[i]) begin
        e.data[i*DATA_W +: DATA_W] = 16'h0100 + 16'(addr[i*ADDR_W +: ADDR_W]);
        mult = 0;
        for (int j = 0; j < MAP_PORT; j++)
          if (mask[j] && addr[j*ADDR_W +: ADDR_W] == addr[i*ADDR_W +: ADDR_W]) mult++;
        if (mult > int'(e.passes)) e.passes = PASS_W'(mult);
      end
    end
    exp_q.push_back(e);

    @(negedge clk);
    check("req_rdy_idle", req_rdy, 1'b1);
    req_vld  = 1'b1;
    req_mask = mask;
    req_addr = addr;
    rsp_rdy  = (hold < 0);
    @(posedge clk);
    #1;
    req_vld  = 1'b0;
    req_mask = 8'($urandom);
    req_addr = {$urandom, $urandom};

    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      check("req_rdy_busy", req_rdy, 1'b0);
      if (rsp_vld) break;
      if (cyc > 20) begin
        checks++;
        errors++;
        $error("FAIL rsp_timeout observed=no_rsp_vld expected=rsp_vld");
        break;
      end
      if (chk_grant) begin
        g = (grant_q.size() != 0) ? grant_q.pop_front() : '0;
        check("map_vld_pass", map_vld, g);
      end else begin
        check("map_vld_nonzero", |map_vld, 1'b1);
      end
      check("map_addr", map_addr, addr);
    end
    check("latency", cyc, int'(e.passes) + 1);
    check("grants_left", grant_q.size(), 0);
    grant_q.delete();
    got = exp_q.pop_front();
    check("rsp_data", rsp_data, got.data);
    check("rsp_passes", rsp_passes, got.passes);
    check("map_vld_done", map_vld, '0);

    if (hold > 0) begin
      if (pulse_req) begin
        req_vld  = 1'b1;
        req_mask = 8'hFF;
      end
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        if (c == 1) req_vld = 1'b0;
        check("bp_rsp_vld", rsp_vld, 1'b1);
        check("bp_rsp_data", rsp_data, got.data);
        check("bp_rsp_passes", rsp_passes, got.passes);
        check("bp_req_rdy", req_rdy, 1'b0);
      end
      req_vld = 1'b0;
    end
    rsp_rdy = 1'b1;
    @(posedge clk);
    #1;
    rsp_rdy = 1'b0;
    @(negedge clk);
    check("post_rsp_vld", rsp_vld, 1'b0);
    check("post_req_rdy", req_rdy, 1'b1);
  endtask

  logic [MAP_PORT*ADDR_W-1:0] a;

  initial begin
    reset    = 1'b1;
    req_vld  = 1'b0;
    req_mask = '0;
    req_addr = '0;
    rsp_rdy  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // No conflicts: addrs 0..7, one pass.
    for (int i = 0; i < MAP_PORT; i++) a[i*ADDR_W +: ADDR_W] = ADDR_W'(i);
    grant_q.push_back(8'hFF);
    run_req(8'hFF, a, 0, 1'b1, 1'b0);

    // Full conflict on register 3: one lane per pass, lowest first.
    for (int i = 0; i < MAP_PORT; i++) begin
      a[i*ADDR_W +: ADDR_W] = 5'd3;
      grant_q.push_back(8'(1 << i));
    end
    run_req(8'hFF, a, 0, 1'b1, 1'b0);

    // Partial conflict: lane0..7 = {5,5,2,5,2,7,0,1}.
    a = {5'd1, 5'd0, 5'd7, 5'd2, 5'd5, 5'd2, 5'd5, 5'd5};
    grant_q.push_back(8'hE5);
    grant_q.push_back(8'h12);
    grant_q.push_back(8'h08);
    run_req(8'hFF, a, 0, 1'b1, 1'b0);

    // Masked lanes 1 and 3 share address 4; other lanes carry a decoy address.
    for (int i = 0; i < MAP_PORT; i++) a[i*ADDR_W +: ADDR_W] = 5'd9;
    a[1*ADDR_W +: ADDR_W] = 5'd4;
    a[3*ADDR_W +: ADDR_W] = 5'd4;
    grant_q.push_back(8'h02);
    grant_q.push_back(8'h08);
    run_req(8'h0A, a, 0, 1'b1, 1'b0);

    // Empty mask: straight to DONE, no mapper activity.
    run_req(8'h00, a, 0, 1'b1, 1'b0);

    // Back-pressure for 5 cycles with ignored request pulses.
    a = {5'd1, 5'd0, 5'd7, 5'd2, 5'd5, 5'd2, 5'd5, 5'd5};
    run_req(8'hFF, a, 5, 1'b0, 1'b1);

    // rsp_rdy already high when the response appears.
    for (int i = 0; i < MAP_PORT; i++) a[i*ADDR_W +: ADDR_W] = ADDR_W'(20 + (i % 3));
    run_req(8'hB7, a, -1, 1'b0, 1'b0);

    // Reset during pass 2 of 4.
    for (int i = 0; i < MAP_PORT; i++) a[i*ADDR_W +: ADDR_W] = 5'd6;
    @(negedge clk);
    req_vld  = 1'b1;
    req_mask = 8'h0F;
    req_addr = a;
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    @(negedge clk);
    check("abort_pass1", map_vld, 8'h01);
    @(negedge clk);
    check("abort_pass2", map_vld, 8'h02);
    reset = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_no_rsp", rsp_vld, 1'b0);
      check("abort_idle", req_rdy, 1'b1);
    end

    // Normal traffic after the abort, small address range to force conflicts.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < MAP_PORT; i++) a[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 3));
      run_req(8'($urandom_range(1, 255)), a, t % 2, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_map_sched.md
# vector_map_sched

Sequencer in front of the vector mapper. It accepts one gather request per transaction: a lane mask plus one register address per lane. It splits the request into conflict-free passes, because the mapper serves only the lowest lane when two lanes name the same address. It drives each pass into the mapper, collects the per-lane data into a result buffer, and returns the complete vector with a valid/ready handshake.

## Interface
Parameters:
- MAP_PORT, 8: lane count; must match the attached mapper.
- ADDR_W, $clog2(VECTOR_REG_DEPTH): lane address width.
- DATA_W, VECTOR_REG_WIDTH: lane data width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk, in, 1: clock.
  - reset, in, 1: asynchronous, active-high reset.
- Request channel:
  - req_vld, in, 1: request valid.
  - req_rdy, out, 1: scheduler idle, request can be accepted.
  - req_mask, in, [MAP_PORT]: lanes participating in the request.
  - req_addr, in, ADDR_W x MAP_PORT: per-lane register address.
- Mapper side:
  - map_vld, out, 1 x MAP_PORT: lanes granted in the current pass.
  - map_addr, out, ADDR_W x MAP_PORT: per-lane address to the mapper.
  - map_data, in, DATA_W x MAP_PORT: mapper output, combinational and same cycle.
- Response channel:
  - rsp_vld, out, 1: result ready.
  - rsp_rdy, in, 1: consumer accepts result.
  - rsp_data, out, DATA_W x MAP_PORT: gathered data; unmasked lanes are 0.
  - rsp_passes, out, $clog2(MAP_PORT)+1: number of passes used.

## Operation
- FSM states are IDLE, ISSUE and DONE.
- IDLE:
  - req_rdy=1.
  - On req_vld&&req_rdy: register req_addr, load pending=req_mask, clear the result buffer and the pass counter.
  - Next state is ISSUE if req_mask!=0, otherwise DONE.
- Grant rule (ISSUE): lane i is granted iff pending[i] is set and no lane k<i has pending[k] set with addr[k]==addr[i]. Exactly one lane per distinct pending address is granted, always the lowest-indexed one.
- ISSUE, every cycle:
  - map_vld=grant and map_addr=registered addr.
  - At the clock edge, capture map_data[i] into the buffer for every granted lane.
  - Update pending &= ~grant and increment the pass counter.
  - Go to DONE when pending&~grant==0.
- DONE:
  - rsp_vld=1, with rsp_data and rsp_passes stable.
  - On rsp_rdy, go to IDLE.
- Pass count equals the maximum multiplicity of any address among the masked lanes. It lies in 1..MAP_PORT, or is 0 for an empty mask.
- Outside ISSUE, map_vld is all 0. map_addr keeps its registered value.

## Timing
- Reset values:
  - State is IDLE, so req_rdy=1.
  - rsp_vld=0, map_vld=0, map_addr=0, rsp_data=0, rsp_passes=0, pending=0.
- Latency: a request accepted at edge T with P passes drives ISSUE during cycles T+1..T+P. rsp_vld rises in cycle T+P+1. For an empty mask, rsp_vld rises in cycle T+1.
- Handshake:
  - req_rdy is 0 outside IDLE. Requests are never buffered.
  - Once rsp_vld is asserted it holds until rsp_rdy. Data must not change while rsp_vld=1 && !rsp_rdy.
  - rsp_rdy may already be high when rsp_vld rises; the response then completes in one cycle.
  - A new request can be accepted in the cycle after the response handshake. There is no back-to-back overlap.
- map_data is sampled only for granted lanes. Non-granted lanes keep their buffered values.
- Reset asserted mid-ISSUE or mid-DONE:
  - The transaction is aborted and no response is produced.
  - All outputs return to their reset values asynchronously.
- req_vld while busy is ignored. The requester holds it until req_rdy.

## Structure
- Shared package vector_pkg:
  - VECTOR_REG_DEPTH and VECTOR_REG_WIDTH constants (existing).
  - New typedef map_sched_state_e for {IDLE, ISSUE, DONE}.
- Sub-module vector_map_grant: purely combinational.
  - Inputs: pending and addr.
  - Output: the grant vector.
  - Implemented as an O(MAP_PORT²) priority compare. Kept separate so it can be unit-tested exhaustively.
- The mapper is instantiated by the parent, not inside this block.

## Test plan
- No conflicts: mask 0xFF, addrs 0..7, mapper data = 0x100+addr → one pass; rsp_data[i]=0x100+i; rsp_passes=1; rsp_vld in cycle T+2.
- Full conflict: mask 0xFF, all addr=3 → 8 passes with map_vld 0x01,0x02,…,0x80; every lane = data of reg 3; rsp_passes=8.
- Partial conflict: addrs {5,5,2,5,2,7,0,1}, mask 0xFF → pass 1 grant 0xE5, pass 2 grant 0x12, pass 3 grant 0x08; rsp_passes=3.
- Masking and empty: mask 0x0A, addrs 4,4 on lanes 1,3 → 2 passes; lanes 0,2,4–7 read 0. Mask 0x00 → rsp_vld at T+1, rsp_passes=0, map_vld never asserted.
- Back-pressure: rsp_rdy held 0 for 5 cycles → rsp_vld, rsp_data and rsp_passes stable; req_rdy=0; req_vld pulses ignored. rsp_rdy=1 → IDLE next cycle, and a new request is accepted.
- Reset mid-ISSUE (pass 2 of 4) → all outputs at reset values immediately; no rsp_vld. The next request completes normally.
